// File: rtl/lc3_boot_loader.sv
// LC-3 boot loader: parses a big-endian object image (origin, length, data words) from a byte
// stream and writes it through the memory special-input port. Optional checksum: LC3_BOOT_CHECKSUM_EN.
module lc3_boot_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned WORD_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] MARSpcIn,
    output logic [WORD_W-1:0] MDRSpcIn,
    output logic              ldMARSpcIn,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] words_loaded
);

    typedef enum logic [3:0] {
        ORIG_HI, ORIG_LO, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR
`ifdef LC3_BOOT_CHECKSUM_EN
        , CSUM_HI, CSUM_LO
`endif
    } state_t;

    localparam logic [31:0] TIMER_LAST = (TIMEOUT_CYCLES == 0) ? '0 : 32'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            nextState;
    logic [7:0]        hiByte;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] remain;
    logic [31:0]       timer;
    logic              accept;
    logic              counting;
    logic              timedOut;
    logic [WORD_W-1:0] byteWord;
`ifdef LC3_BOOT_CHECKSUM_EN
    logic [WORD_W-1:0] csum;
`endif

    assign accept   = in_valid && in_ready;
    assign byteWord = {hiByte, in_data};

    always_comb begin
        counting  = !(state inside {ORIG_HI, WRITE, DONE, ERROR});
        timedOut  = (TIMEOUT_CYCLES != 0) && counting && !accept && (timer == TIMER_LAST);
        nextState = state;
        case (state)
            ORIG_HI: if (accept) nextState = ORIG_LO;
            ORIG_LO: if (accept) nextState = LEN_HI;
            LEN_HI:  if (accept) nextState = LEN_LO;
            LEN_LO: begin
                if (accept) begin
`ifdef LC3_BOOT_CHECKSUM_EN
                    nextState = (byteWord == '0) ? CSUM_HI : DATA_HI;
`else
                    nextState = (byteWord == '0) ? DONE : DATA_HI;
`endif
                end
            end
            DATA_HI: if (accept) nextState = DATA_LO;
            DATA_LO: if (accept) nextState = WRITE;
            WRITE: begin
`ifdef LC3_BOOT_CHECKSUM_EN
                nextState = (remain == WORD_W'(1)) ? CSUM_HI : DATA_HI;
`else
                nextState = (remain == WORD_W'(1)) ? DONE : DATA_HI;
`endif
            end
`ifdef LC3_BOOT_CHECKSUM_EN
            CSUM_HI: if (accept) nextState = CSUM_LO;
            CSUM_LO: if (accept) nextState = (byteWord == csum) ? DONE : ERROR;
`endif
            default: nextState = state;
        endcase
        // A byte arriving on the last allowed cycle still wins over the timeout.
        if (timedOut) nextState = ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ORIG_HI;
            in_ready     <= 1'b1;
            MARSpcIn     <= '0;
            MDRSpcIn     <= '0;
            ldMARSpcIn   <= 1'b0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            hiByte       <= '0;
            addr         <= '0;
            remain       <= '0;
            timer        <= '0;
`ifdef LC3_BOOT_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state      <= nextState;
            in_ready   <= !(nextState inside {WRITE, DONE, ERROR});
            ldMARSpcIn <= (nextState == WRITE);
            cpu_hold   <= (nextState != DONE);
            done       <= (nextState == DONE);
            error      <= (nextState == ERROR);

            if (accept)        timer <= '0;
            else if (counting) timer <= timer + 32'd1;

            if (accept) begin
                case (state)
                    ORIG_HI, LEN_HI, DATA_HI: hiByte <= in_data;
                    ORIG_LO: addr <= byteWord;
                    LEN_LO: begin
                        remain <= byteWord;
`ifdef LC3_BOOT_CHECKSUM_EN
                        csum   <= '0;
`endif
                    end
                    DATA_LO: begin
                        MDRSpcIn <= byteWord;
                        MARSpcIn <= addr;
`ifdef LC3_BOOT_CHECKSUM_EN
                        csum     <= csum ^ byteWord;
`endif
                    end
`ifdef LC3_BOOT_CHECKSUM_EN
                    CSUM_HI: hiByte <= in_data;
`endif
                    default: ;
                endcase
            end

            if (state == WRITE) begin
                addr         <= addr + WORD_W'(1);
                remain       <= remain - WORD_W'(1);
                words_loaded <= words_loaded + WORD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lc3_boot_loader.sv
// Self-checking bench for lc3_boot_loader: directed and randomized loads checked against
// an image-level model of the expected memory writes. Honours LC3_BOOT_CHECKSUM_EN.
module tb_lc3_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] MARSpcIn;
    logic [15:0] MDRSpcIn;
    logic        ldMARSpcIn;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] obsQ[$];
    logic        ldPrev = 1'b0;

    lc3_boot_loader #(.TIMEOUT_CYCLES(10), .WORD_W(16)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .MARSpcIn(MARSpcIn), .MDRSpcIn(MDRSpcIn), .ldMARSpcIn(ldMARSpcIn),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Record every write strobe; a strobe held for two samples is a fault.
    always @(negedge clk) begin
        if (ldMARSpcIn === 1'b1) begin
            obsQ.push_back({MARSpcIn, MDRSpcIn});
            chk("ldPulseWidth", {31'd0, ldPrev}, 32'd0);
        end
        ldPrev = ldMARSpcIn;
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        in_valid = 1'b0;
        step(1);
        reset = 1'b0;
        obsQ.delete();
    endtask

    task automatic checkResetVals(input string tag);
        chk({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "/MAR"}, {16'd0, MARSpcIn}, 32'd0);
        chk({tag, "/MDR"}, {16'd0, MDRSpcIn}, 32'd0);
        chk({tag, "/ld"}, {31'd0, ldMARSpcIn}, 32'd0);
        chk({tag, "/cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        chk({tag, "/done"}, {31'd0, done}, 32'd0);
        chk({tag, "/error"}, {31'd0, error}, 32'd0);
        chk({tag, "/words"}, {16'd0, words_loaded}, 32'd0);
    endtask

    // Present a byte until the loader takes it (ready is sampled before the accepting edge).
    task automatic sendByte(input logic [7:0] b);
        bit accepted = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 30 && !accepted; i++) begin
            if (in_ready) accepted = 1'b1;
            step(1);
        end
        in_valid = 1'b0;
        chk("byteAccepted", {31'd0, accepted}, 32'd1);
    endtask

    task automatic runLoad(input string name, input logic [15:0] origin, input logic [15:0] words[$],
                           input int unsigned gapMax, input bit corrupt);
        logic [7:0]  bytes[$];
        logic [31:0] expQ[$];
        logic [15:0] len;
        logic [15:0] csum;
        bit          expOk;
        int          nCmp;
        doReset();
        len  = 16'(words.size());
        csum = '0;
        bytes = {origin[15:8], origin[7:0], len[15:8], len[7:0]};
        foreach (words[i]) begin
            bytes.push_back(words[i][15:8]);
            bytes.push_back(words[i][7:0]);
            csum ^= words[i];
            expQ.push_back({origin + 16'(i), words[i]});
        end
`ifdef LC3_BOOT_CHECKSUM_EN
        if (corrupt) csum ^= 16'h0001;
        bytes.push_back(csum[15:8]);
        bytes.push_back(csum[7:0]);
        expOk = !corrupt;
`else
        expOk = 1'b1;
`endif
        foreach (bytes[i]) begin
            sendByte(bytes[i]);
            step($urandom_range(0, gapMax));
        end
        for (int i = 0; i < 20 && !(done || error); i++) step(1);
        chk({name, "/writeCount"}, expQ.size(), obsQ.size());
        nCmp = (expQ.size() < obsQ.size()) ? expQ.size() : obsQ.size();
        for (int i = 0; i < nCmp; i++) chk({name, "/write"}, obsQ[i], expQ[i]);
        chk({name, "/done"}, {31'd0, done}, {31'd0, expOk});
        chk({name, "/error"}, {31'd0, error}, {31'd0, !expOk});
        chk({name, "/cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !expOk});
        chk({name, "/in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({name, "/words"}, {16'd0, words_loaded}, {16'd0, len});
        if (len != 0) chk({name, "/MARhold"}, {16'd0, MARSpcIn}, {16'd0, origin + len - 16'd1});
        if (corrupt === 1'b1 && expOk) chk({name, "/corruptIgnored"}, 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w[$];
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        step(2);
        checkResetVals("reset");
        reset = 1'b0;
        step(1);

        w = {16'h1234, 16'hABCD};
        runLoad("basic", 16'h3000, w, 0, 1'b0);
`ifdef LC3_BOOT_CHECKSUM_EN
        runLoad("badCsum", 16'h3000, w, 0, 1'b1);
`endif
        w = {};
        runLoad("lenZero", 16'h4000, w, 2, 1'b0);
        w = {16'h0001, 16'h0002};
        runLoad("wrap", 16'hFFFF, w, 1, 1'b0);

        // Timeout: idle after the origin word; error must fire on the tenth idle cycle.
        doReset();
        sendByte(8'h30);
        sendByte(8'h00);
        step(9);
        chk("timeout/notYet", {31'd0, error}, 32'd0);
        step(1);
        chk("timeout/error", {31'd0, error}, 32'd1);
        chk("timeout/cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("timeout/in_ready", {31'd0, in_ready}, 32'd0);
        in_data  = 8'h00;
        in_valid = 1'b1;
        step(5);
        in_valid = 1'b0;
        chk("timeout/sticky", {31'd0, error}, 32'd1);
        chk("timeout/noDone", {31'd0, done}, 32'd0);
        chk("timeout/words", {16'd0, words_loaded}, 32'd0);
        chk("timeout/noWrites", obsQ.size(), 32'd0);

        // Reset mid-load, then a full load must succeed from scratch.
        doReset();
        sendByte(8'h30); sendByte(8'h00); sendByte(8'h00); sendByte(8'h01); sendByte(8'h12);
        reset = 1'b1;
        step(1);
        checkResetVals("midReset");
        reset = 1'b0;
        w = {16'h5A5A};
        runLoad("afterReset", 16'h3100, w, 1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            logic [15:0] org;
            bit          bad;
            int unsigned n;
            org = (t % 3 == 0) ? 16'($urandom_range(16'hFFFA, 16'hFFFF)) : 16'($urandom);
            n = $urandom_range(1, 6);
            w = {};
            for (int i = 0; i < int'(n); i++) w.push_back(16'($urandom));
`ifdef LC3_BOOT_CHECKSUM_EN
            bad = ($urandom_range(0, 3) == 0);
`else
            bad = 1'b0;
`endif
            runLoad("random", org, w, 3, bad);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
